// File: rtl/seg7_mux_driver.sv
// rtl/seg7_mux_driver.sv - multiplexed 7-segment display driver (optional blink via BLINK_EN)
module seg7_mux_driver #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   digits_in,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
`ifdef BLINK_EN
  input  logic [N_DIGITS-1:0]     blink_mask,
`endif
  output logic [6:0]              segments,
  output logic [N_DIGITS-1:0]     digit_sel
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [4*N_DIGITS-1:0] shadow;
  logic [CNT_W-1:0]      scan_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  advance;
  logic [3:0]            cur_nibble;
  logic                  upper_zero;
  logic                  lz_hit;
  logic                  lz_off;
  logic                  blink_off;

  assign advance    = (scan_cnt == CNT_LAST);
  assign cur_nibble = shadow[4*idx +: 4];

  // Segment patterns in gfedcba order; hex letters only when hex_mode, else "F" as error mark.
  function automatic logic [6:0] decode(input logic [3:0] code, input logic hex);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'b0111111;
      4'd1:    pat = 7'b0000110;
      4'd2:    pat = 7'b1011011;
      4'd3:    pat = 7'b1001111;
      4'd4:    pat = 7'b1100110;
      4'd5:    pat = 7'b1101101;
      4'd6:    pat = 7'b1111101;
      4'd7:    pat = 7'b0000111;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1101111;
      4'd10:   pat = hex ? 7'b1110111 : 7'b1110001;
      4'd11:   pat = hex ? 7'b1111100 : 7'b1110001;
      4'd12:   pat = hex ? 7'b0111001 : 7'b1110001;
      4'd13:   pat = hex ? 7'b1011110 : 7'b1110001;
      4'd14:   pat = hex ? 7'b1111001 : 7'b1110001;
      default: pat = 7'b1110001;
    endcase
    return pat;
  endfunction

  // Shadow register: captures a new display value on the load strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow <= '0;
    else if (load) shadow <= digits_in;
  end

  // Scan timer and digit index: each digit stays selected for SCAN_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (advance) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Leading-zero detect: walk from the top nibble down, tracking "everything so far is zero".
  always_comb begin
    upper_zero = 1'b1;
    lz_hit     = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (shadow[4*i +: 4] != 4'd0) upper_zero = 1'b0;
      if (i == int'(idx)) lz_hit = upper_zero;
    end
  end

  // Digit 0 is always shown so an all-zero value still reads "0".
  assign lz_off = lz_blank && lz_hit && (idx != '0);

`ifdef BLINK_EN
  localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);

  logic [FRM_W-1:0] frame_cnt;
  logic             blink_phase;

  // Frame counter advances once per full scan; phase flips every BLINK_DIV frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (advance && (idx == IDX_LAST)) begin
      if (frame_cnt == FRM_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink_off = blink_phase && blink_mask[idx];
`else
  assign blink_off = 1'b0;
`endif

  // Output register: digit enable and pattern for the digit currently indexed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments  <= '0;
      digit_sel <= '0;
    end else begin
      digit_sel <= {{(N_DIGITS-1){1'b0}}, 1'b1} << idx;
      segments  <= (lz_off || blink_off) ? 7'd0 : decode(cur_nibble, hex_mode);
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb/tb_seg7_mux_driver.sv - directed scoreboard bench for seg7_mux_driver
module tb_seg7_mux_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   digits_in = '0;
  logic          hex_mode = 1'b0;
  logic          lz_blank = 1'b0;
`ifdef BLINK_EN
  logic [3:0]    blink_mask = '0;
`endif
  logic [6:0]    segments;
  logic [3:0]    digit_sel;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_sel_q[$];
  logic [6:0] exp_seg_q[$];

  seg7_mux_driver #(.N_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .digits_in(digits_in),
    .hex_mode(hex_mode),
    .lz_blank(lz_blank),
`ifdef BLINK_EN
    .blink_mask(blink_mask),
`endif
    .segments(segments),
    .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] c, input logic hex);
    case (c)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return hex ? 7'b1110111 : 7'b1110001;
      4'hB: return hex ? 7'b1111100 : 7'b1110001;
      4'hC: return hex ? 7'b0111001 : 7'b1110001;
      4'hD: return hex ? 7'b1011110 : 7'b1110001;
      4'hE: return hex ? 7'b1111001 : 7'b1110001;
      default: return 7'b1110001;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Push expected samples for digits first_d..3 of one frame; bmask digits show blank.
  task automatic push_digits(input logic [15:0] value, input logic hex, input logic lz,
                             input int first_d, input logic [3:0] bmask);
    for (int d = first_d; d < ND; d++) begin
      logic [3:0] nib;
      logic       blank;
      logic [15:0] upper;
      nib   = value[4*d +: 4];
      upper = value >> (4*d);
      blank = (lz && d != 0 && upper == 16'h0) || bmask[d];
      for (int c = 0; c < SD; c++) begin
        exp_sel_q.push_back(4'b0001 << d);
        exp_seg_q.push_back(blank ? 7'b0 : ref_seg(nib, hex));
      end
    end
  endtask

  // Pop and compare one expected sample per cycle, starting with the current sample.
  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (exp_sel_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL %s_empty observed=empty expected=entry", tag);
      end else begin
        logic [3:0] es;
        logic [6:0] eg;
        es = exp_sel_q.pop_front();
        eg = exp_seg_q.pop_front();
        check($sformatf("%s_sel[%0d]", tag, i), {4'b0, digit_sel}, {4'b0, es});
        check($sformatf("%s_seg[%0d]", tag, i), {1'b0, segments}, {1'b0, eg});
      end
    end
  endtask

  // Advance to the first sample of a frame (digit 0 newly selected), bounded.
  task automatic sync_frame();
    logic [3:0] last;
    bit found;
    found = 0;
    last  = digit_sel;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (digit_sel == 4'b0001 && last != 4'b0001) found = 1;
      else last = digit_sel;
    end
    tests++;
    assert (found) else begin
      fails++;
      $error("FAIL sync_frame observed=timeout expected=frame_start");
    end
  endtask

  task automatic load_value(input logic [15:0] v);
    @(negedge clk);
    digits_in = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic frame_test(input logic [15:0] v, input logic hex, input logic lz, input string tag);
    hex_mode = hex;
    lz_blank = lz;
    load_value(v);
    push_digits(v, hex, lz, 0, 4'b0);
    sync_frame();
    drain(16, tag);
  endtask

  initial begin
    // reset state, including across clock edges
    #2;
    check("rst_seg", {1'b0, segments}, 8'd0);
    check("rst_sel", {4'b0, digit_sel}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_sel", {4'b0, digit_sel}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_sel", {4'b0, digit_sel}, 8'b0001);
    check("first_seg", {1'b0, segments}, {1'b0, 7'b0111111});

    // basic scan and wrap
    frame_test(16'h1234, 1'b0, 1'b0, "scan1234");
    @(negedge clk);
    check("wrap_sel", {4'b0, digit_sel}, 8'b0001);

    // leading-zero blanking with hex letter, then live hex_mode change
    frame_test(16'h00A0, 1'b1, 1'b1, "lz00A0");
    sync_frame();
    repeat (4) @(negedge clk);
    check("hex_before", {1'b0, segments}, {1'b0, 7'b1110111});
    hex_mode = 1'b0;
    @(negedge clk);
    check("hex_after", {1'b0, segments}, {1'b0, 7'b1110001});

    frame_test(16'h0000, 1'b0, 1'b1, "zero");
    frame_test(16'hCDEB, 1'b1, 1'b0, "hexCDEB");
    frame_test(16'h9876, 1'b0, 1'b0, "dec9876");
    frame_test(16'hFA05, 1'b0, 1'b1, "errFA05");

    // load coinciding with the digit-advance edge
    hex_mode = 1'b0;
    lz_blank = 1'b0;
    load_value(16'h1234);
    sync_frame();
    @(negedge clk);
    @(negedge clk);
    digits_in = 16'h5678;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("adv_old_sel", {4'b0, digit_sel}, 8'b0001);
    check("adv_old_seg", {1'b0, segments}, {1'b0, 7'b1100110});
    push_digits(16'h5678, 1'b0, 1'b0, 1, 4'b0);
    @(negedge clk);
    drain(12, "adv_new");

    // asynchronous reset mid-scan at scan count 2
    lz_blank = 1'b1;
    sync_frame();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_seg", {1'b0, segments}, 8'd0);
    check("arst_sel", {4'b0, digit_sel}, 8'd0);
    @(negedge clk);
    check("arst_hold_sel", {4'b0, digit_sel}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    push_digits(16'h0000, 1'b0, 1'b1, 0, 4'b0);
    drain(16, "post_rst");

`ifdef BLINK_EN
    // blink: digit 1 blank in frames 2-3, visible in 0-1 and 4-5
    lz_blank = 1'b0;
    blink_mask = 4'b0010;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    digits_in = 16'h1234;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    push_digits(16'h1234, 1'b0, 1'b0, 1, 4'b0000);
    push_digits(16'h1234, 1'b0, 1'b0, 0, 4'b0000);
    push_digits(16'h1234, 1'b0, 1'b0, 0, 4'b0010);
    push_digits(16'h1234, 1'b0, 1'b0, 0, 4'b0010);
    push_digits(16'h1234, 1'b0, 1'b0, 0, 4'b0000);
    push_digits(16'h1234, 1'b0, 1'b0, 0, 4'b0000);
    drain(92, "blink");
`endif

    check("queue_left", 8'(exp_sel_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_mux_driver.md
SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits (range 2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, clock cycles each digit stays selected (minimum 2).
REQ-003 SHALL have parameter BLINK_DIV, default 64, full scan frames per blink phase (used only with BLINK_EN).
REQ-004 SHALL have port clk  input  1  single rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port load  input  1  strobe; latches digits_in into the shadow register.
REQ-007 SHALL have port digits_in  input  4*N_DIGITS  packed nibbles; nibble 0 (bits 3:0) is the least significant digit.
REQ-008 SHALL have port hex_mode  input  1  1 = display codes 10..15 as A,b,C,d,E,F.
REQ-009 SHALL have port lz_blank  input  1  1 = suppress leading zeros.
REQ-010 SHALL have port blink_mask  input  N_DIGITS  per-digit blink enable (present only with BLINK_EN).
REQ-011 SHALL have port segments  output  7  registered pattern, bit order gfedcba, active-high.
REQ-012 SHALL have port digit_sel  output  N_DIGITS  registered one-hot active-high digit enable.

Function
REQ-013 Shadow register SHALL load digits_in on the rising edge where load=1 and hold otherwise.
REQ-014 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; at terminal count the digit index SHALL advance by 1, wrapping from N_DIGITS-1 to 0.
REQ-015 Each cycle, segments and digit_sel SHALL be registered from the current shadow nibble and index; latency shadow->pins is 1 cycle, so load->pins is 2 cycles.
REQ-016 digit_sel SHALL be exactly one-hot at bit index at all times after the first post-reset edge; it is never all-zero and never multi-hot outside reset.
REQ-017 Codes 0..9 SHALL map to 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
REQ-018 With hex_mode=1, codes 10..15 SHALL map to 1110111, 1111100, 0111001, 1011110, 1111001, 1110001.
REQ-019 With hex_mode=0, codes 10..15 SHALL all map to 1110001 (letter F, error indication).
REQ-020 With lz_blank=1, a digit SHALL show 0000000 if it and all more-significant nibbles are zero; digit 0 SHALL never be blanked (all-zero value shows single "0").
REQ-021 hex_mode and lz_blank changes SHALL take effect on the next registered output, without waiting for a digit advance.
REQ-022 load coinciding with a digit advance SHALL be handled with no dropped or duplicated update; the new digit shows the new shadow value one cycle later.

Reset
REQ-023 While rst_n=0: segments=0000000, digit_sel=all zero, shadow=0, scan counter=0, digit index=0, blink phase=0.
REQ-024 Reset assertion SHALL act asynchronously, including mid-scan; deassertion is synchronous to clk and the first rising edge after it SHALL drive digit_sel=one-hot bit 0 with the decode of shadow nibble 0.

Configuration
REQ-025 Macro BLINK_EN defined: a frame counter increments on each wrap from digit N_DIGITS-1 to 0; every BLINK_DIV frames blink phase toggles; while phase=1, digits with blink_mask bit set SHALL output 0000000 (digit_sel unaffected).
REQ-026 Macro BLINK_EN undefined: blink_mask port, frame counter and phase logic SHALL be absent; behaviour is otherwise identical.

Verification
REQ-027 N_DIGITS=4, SCAN_DIV=4, load 0x1234 -> digit_sel 0001,0010,0100,1000 each held 4 cycles; segments 1100110,1001111,1011011,0000110 respectively, then wrap to 0001.
REQ-028 Load 0x00A0, hex_mode=1, lz_blank=1 -> digits 3,2 blank; digit 1 1110111; digit 0 0111111; hex_mode=0 -> digit 1 becomes 1110001 on the next cycle.
REQ-029 Load 0x0000, lz_blank=1 -> digits 3..1 0000000, digit 0 0111111.
REQ-030 Pulse load with new value on the digit-advance cycle -> newly selected digit shows new value one cycle later; no glitch pattern.
REQ-031 Assert rst_n=0 mid-scan at scan count 2 -> outputs zero immediately without a clock edge; after release, first edge gives digit_sel=0001.
REQ-032 BLINK_EN, BLINK_DIV=2, blink_mask=0010 -> digit 1 blank during frames 2-3, visible during frames 0-1 and 4-5; other digits never blank.
